// File: rtl/accelbrot_com_add_arb.sv
// rtl/accelbrot_com_add_arb.sv - Round-robin arbiter time-sharing one word-serial multiprecision adder
// Optional macro ACCELBROT_COM_ADD_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins) instead of round-robin.

module accelbrot_com_add #(
   parameter int WWIDTH = 34
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [WWIDTH-1:0] a_i,
   input  logic [WWIDTH-1:0] b_i,
   input  logic              ab_valid_i,
   input  logic              ab_start_i,
   output logic [WWIDTH-1:0] q_o,
   output logic              q_valid_o,
   output logic              q_start_o
);

   logic [WWIDTH-1:0] sum_q;
   logic [WWIDTH:0]   sum_d;
   logic              carry_q;
   logic              valid_q;
   logic              start_q;

   // ab_start drops the stored carry so operations never chain into each other
   always_comb begin
      sum_d = {1'b0, a_i} + {1'b0, b_i} + {{WWIDTH{1'b0}}, carry_q & ~ab_start_i};
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sum_q   <= '0;
         carry_q <= 1'b0;
         valid_q <= 1'b0;
         start_q <= 1'b0;
      end else begin
         valid_q <= ab_valid_i;
         start_q <= ab_valid_i & ab_start_i;
         if (ab_valid_i) begin
            sum_q   <= sum_d[WWIDTH-1:0];
            carry_q <= sum_d[WWIDTH];
         end
      end
   end

   assign q_o       = sum_q;
   assign q_valid_o = valid_q;
   assign q_start_o = start_q;

endmodule

module accelbrot_com_add_arb #(
   parameter int WWIDTH = 34,
   parameter int NREQ   = 4,
   parameter int NWORDS = 4
) (
   input  logic                                  clk,
   input  logic                                  rstn,
   input  logic [NREQ-1:0]                       req,
   input  logic [NREQ*WWIDTH-1:0]                req_a,
   input  logic [NREQ*WWIDTH-1:0]                req_b,
   output logic [NREQ-1:0]                       rd,
   output logic                                  rd_first,
   output logic                                  rd_last,
   output logic [WWIDTH-1:0]                     q,
   output logic                                  q_valid,
   output logic                                  q_start,
   output logic                                  q_last,
   output logic [((NREQ > 2) ? $clog2(NREQ) : 1)-1:0] q_id,
   output logic                                  busy
);

   localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;
   localparam int CW  = $clog2(NWORDS);

   typedef enum logic {S_IDLE, S_ISSUE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IDW-1:0]  sel_q, sel_d;
   logic [IDW-1:0]  grant_idx;
   logic            grant_any;
   logic            last_word;
   logic            q_last_q;
   logic [IDW-1:0]  q_id_q;

   logic [WWIDTH-1:0] add_a, add_b;
   logic              add_valid, add_start;

   assign last_word = (cnt_q == CW'(NWORDS-1));

`ifdef ACCELBROT_COM_ADD_ARB_FIXED_PRIO_EN
   // Descending scan so the lowest requesting index is the final write
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         if (req[k]) begin
            grant_any = 1'b1;
            grant_idx = IDW'(k);
         end
      end
   end
`else
   logic [IDW-1:0] ptr_q, ptr_d;

   // Descending scan of offsets from ptr so the nearest requester wins
   always_comb begin
      int j;
      j         = 0;
      grant_any = 1'b0;
      grant_idx = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         j = (int'(ptr_q) + k) % NREQ;
         if (req[j]) begin
            grant_any = 1'b1;
            grant_idx = IDW'(j);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (state_q == S_IDLE && grant_any) begin
         ptr_d = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      case (state_q)
         S_IDLE: begin
            if (grant_any) begin
               state_d = S_ISSUE;
               cnt_d   = '0;
               sel_d   = grant_idx;
            end
         end
         S_ISSUE: begin
            cnt_d = cnt_q + CW'(1);
            if (last_word) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      rd        = '0;
      rd_first  = 1'b0;
      rd_last   = 1'b0;
      busy      = 1'b0;
      add_a     = '0;
      add_b     = '0;
      add_valid = 1'b0;
      add_start = 1'b0;
      if (state_q == S_ISSUE) begin
         rd[sel_q] = 1'b1;
         rd_first  = (cnt_q == '0);
         rd_last   = last_word;
         busy      = 1'b1;
         add_a     = req_a[int'(sel_q)*WWIDTH +: WWIDTH];
         add_b     = req_b[int'(sel_q)*WWIDTH +: WWIDTH];
         add_valid = 1'b1;
         add_start = (cnt_q == '0);
      end
   end

   // Tag registers share the adder's one-cycle latency so they line up with q_valid
   always_ff @(posedge clk) begin
      if (!rstn) begin
         q_last_q <= 1'b0;
         q_id_q   <= '0;
      end else begin
         q_last_q <= rd_last;
         if (state_q == S_ISSUE) begin
            q_id_q <= sel_q;
         end
      end
   end

   assign q_last = q_last_q;
   assign q_id   = q_id_q;

   accelbrot_com_add #(
      .WWIDTH (WWIDTH)
   ) u_add (
      .clk        (clk),
      .rstn       (rstn),
      .a_i        (add_a),
      .b_i        (add_b),
      .ab_valid_i (add_valid),
      .ab_start_i (add_start),
      .q_o        (q),
      .q_valid_o  (q_valid),
      .q_start_o  (q_start)
   );

endmodule

// File: tb/tb_accelbrot_com_add_arb.sv
// tb/tb_accelbrot_com_add_arb.sv - Scoreboard bench for accelbrot_com_add_arb against a whole-operand reference model
// Honours ACCELBROT_COM_ADD_ARB_FIXED_PRIO_EN in its arbitration model.

module tb_accelbrot_com_add_arb;

   localparam int W   = 34;
   localparam int NR  = 4;
   localparam int NW  = 4;
   localparam int IDW = 2;

   logic              clk;
   logic              rstn;
   logic [NR-1:0]     req;
   logic [NR*W-1:0]   req_a;
   logic [NR*W-1:0]   req_b;
   logic [NR-1:0]     rd;
   logic              rd_first;
   logic              rd_last;
   logic [W-1:0]      q;
   logic              q_valid;
   logic              q_start;
   logic              q_last;
   logic [IDW-1:0]    q_id;
   logic              busy;

   accelbrot_com_add_arb #(.WWIDTH(W), .NREQ(NR), .NWORDS(NW)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .req      (req),
      .req_a    (req_a),
      .req_b    (req_b),
      .rd       (rd),
      .rd_first (rd_first),
      .rd_last  (rd_last),
      .q        (q),
      .q_valid  (q_valid),
      .q_start  (q_start),
      .q_last   (q_last),
      .q_id     (q_id),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] word;
      bit           st;
      bit           ls;
      int           id;
   } exp_t;

   exp_t         exp_q[$];
   int           checks = 0;
   int           errors = 0;

   logic [W-1:0] opa [NR][NW];
   logic [W-1:0] opb [NR][NW];
   int           idx [NR];
   logic [NR-1:0] req_r;
   logic [NR-1:0] rd_s;
   int           phase;

   // Reference model: state as seen by the DUT between edges
   bit           m_busy;
   int           m_owner;
   int           m_cnt;
   int           m_ptr;
   int           m_start;
   int           m_j;
   bit           m_found;
   logic [NR-1:0] m_exp_rd;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [63:0] r;
      case ($urandom_range(0, 3))
         0: return '1;
         1: return '0;
         default: begin
            r = {$urandom, $urandom};
            return r[W-1:0];
         end
      endcase
   endfunction

   function automatic void new_op(input int i);
      for (int w = 0; w < NW; w++) begin
         opa[i][w] = rand_word();
         opb[i][w] = rand_word();
      end
   endfunction

   // Whole-operand addition, split into words afterwards
   function automatic void push_exp(input int o);
      logic [NW*W:0] sa, sb, ss;
      exp_t e;
      sa = '0;
      sb = '0;
      for (int w = 0; w < NW; w++) begin
         sa[w*W +: W] = opa[o][w];
         sb[w*W +: W] = opb[o][w];
      end
      ss = sa + sb;
      for (int w = 0; w < NW; w++) begin
         e.word = ss[w*W +: W];
         e.st   = (w == 0);
         e.ls   = (w == NW-1);
         e.id   = o;
         exp_q.push_back(e);
      end
   endfunction

   always @(negedge clk) begin
      rd_s     = rd;
      m_exp_rd = '0;
      if (m_busy) m_exp_rd[m_owner] = 1'b1;
      chk("rd", 64'(rd), 64'(m_exp_rd));
      chk("rd_first", 64'(rd_first), 64'(m_busy && m_cnt == 0));
      chk("rd_last", 64'(rd_last), 64'(m_busy && m_cnt == NW-1));
      chk("busy", 64'(busy), 64'(m_busy));
      if (!rstn) begin
         m_busy = 0;
         m_cnt  = 0;
         m_ptr  = 0;
         exp_q.delete();
      end else if (m_busy) begin
         m_cnt++;
         if (m_cnt == NW) begin
            m_busy = 0;
            m_cnt  = 0;
         end
      end else begin
`ifdef ACCELBROT_COM_ADD_ARB_FIXED_PRIO_EN
         m_start = 0;
`else
         m_start = m_ptr;
`endif
         m_found = 0;
         for (int k = 0; k < NR; k++) begin
            m_j = (m_start + k) % NR;
            if (!m_found && req[m_j]) begin
               m_found = 1;
               m_owner = m_j;
            end
         end
         if (m_found) begin
            m_busy = 1;
            m_cnt  = 0;
            m_ptr  = (m_owner + 1) % NR;
            push_exp(m_owner);
         end
      end
   end

   always @(posedge clk) begin
      exp_t e;
      #2;
      if (q_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL q_unexpected actual=%0h required=no_word", q);
         end else begin
            e = exp_q.pop_front();
            chk("q_word", 64'(q), 64'(e.word));
            chk("q_start", 64'(q_start), 64'(e.st));
            chk("q_last", 64'(q_last), 64'(e.ls));
            chk("q_id", 64'(q_id), 64'(e.id));
         end
      end
   end

   task automatic pack();
      req = req_r;
      for (int i = 0; i < NR; i++) begin
         req_a[i*W +: W] = opa[i][idx[i]];
         req_b[i*W +: W] = opb[i][idx[i]];
      end
   endtask

   task automatic drive_cycle();
      @(posedge clk);
      #1;
      if (!rstn) begin
         for (int i = 0; i < NR; i++) idx[i] = 0;
         rstn = 1'b1;
      end else begin
         for (int i = 0; i < NR; i++) begin
            if (rd_s[i]) begin
               idx[i]++;
               if (idx[i] == NW) begin
                  idx[i]   = 0;
                  new_op(i);
                  req_r[i] = (phase == 1);
               end else if (phase == 2 && $urandom_range(0, 5) == 0) begin
                  req_r[i] = 1'b0;
               end
            end
         end
      end
      for (int i = 0; i < NR; i++) begin
         if (!req_r[i] && idx[i] == 0) begin
            if (phase == 1) req_r[i] = 1'b1;
            else if (phase == 2 && $urandom_range(0, 3) == 0) req_r[i] = 1'b1;
         end
      end
      if (phase == 2 && m_busy && m_cnt == 2 && $urandom_range(0, 24) == 0) rstn = 1'b0;
      pack();
   endtask

   function automatic bit drained();
      bit d;
      d = !m_busy && exp_q.size() == 0;
      for (int i = 0; i < NR; i++) if (req_r[i] || idx[i] != 0) d = 0;
      return d;
   endfunction

   initial begin
      int c;
      m_busy = 0;
      m_cnt  = 0;
      m_ptr  = 0;
      m_owner = 0;
      phase  = 0;
      rstn   = 1'b0;
      req_r  = '0;
      for (int i = 0; i < NR; i++) begin
         idx[i] = 0;
         new_op(i);
      end
      opa[2][0] = 34'h3FFFFFFFF; opa[2][1] = 34'h3FFFFFFFF; opa[2][2] = '0; opa[2][3] = '0;
      opb[2][0] = 34'h1;         opb[2][1] = '0;           opb[2][2] = '0; opb[2][3] = '0;
      pack();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_q", 64'(q), 64'h0);
      chk("reset_q_valid", 64'(q_valid), 64'h0);
      chk("reset_q_start", 64'(q_start), 64'h0);
      chk("reset_q_last", 64'(q_last), 64'h0);
      chk("reset_q_id", 64'(q_id), 64'h0);
      rstn     = 1'b1;
      req_r[2] = 1'b1;
      pack();
      for (int n = 0; n < 30; n++) drive_cycle();
      phase = 1;
      for (int n = 0; n < 150; n++) drive_cycle();
      phase = 2;
      for (int n = 0; n < 3000; n++) drive_cycle();
      phase = 3;
      c = 0;
      while (c < 300 && !drained()) begin
         drive_cycle();
         c++;
      end
      chk("drain_complete", 64'(drained()), 64'h1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
